// File: rtl/pulse_timer.sv
// pulse_timer: programmable delayed pulse-train generator with abort and completion strobe
module pulse_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] delay,
    input  logic [WIDTH-1:0] width,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] n_pulses,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pulse_num
);
    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;
    state_t           state_q, state_d;
    logic             launch_q, launch_d;
    logic             pulse_q, busy_q, done_q, done_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, num_q, num_d;
    logic [WIDTH-1:0] dly_q, dly_d, w_q, w_d, lo_q, lo_d, n_q, n_d;
    logic [WIDTH-1:0] w_eff, p_eff;
    logic             last;
    assign w_eff = (width == '0) ? WIDTH'(1) : ((&width) ? width - WIDTH'(1) : width);
    assign p_eff = (period > w_eff) ? period : w_eff + WIDTH'(1);
    assign last  = (n_q != '0) && (num_q + WIDTH'(1) == n_q);
    assign pulse     = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_num = num_q;
    // Next state: launch_q marks the acceptance cycle (busy, still IDLE) before DELAY/HIGH
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        launch_d = 1'b0;
        done_d   = 1'b0;
        num_d    = num_q;
        dly_d    = dly_q;
        w_d      = w_q;
        lo_d     = lo_q;
        n_d      = n_q;
        if (abort && (launch_q || state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch_q) begin
                        state_d = (dly_q == '0) ? HIGH : DELAY;
                        cnt_d   = (dly_q == '0) ? w_q : dly_q;
                    end else if (start && !abort) begin
                        launch_d = 1'b1;
                        dly_d    = delay;
                        w_d      = w_eff;
                        lo_d     = p_eff - w_eff;
                        n_d      = n_pulses;
                        num_d    = '0;
                    end
                end
                DELAY: begin
                    state_d = (cnt_q == WIDTH'(1)) ? HIGH : DELAY;
                    cnt_d   = (cnt_q == WIDTH'(1)) ? w_q : cnt_q - WIDTH'(1);
                end
                HIGH: begin
                    if (cnt_q == WIDTH'(1)) begin
                        num_d   = num_q + WIDTH'(1);
                        state_d = last ? IDLE : LOW;
                        done_d  = last;
                        cnt_d   = lo_q;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
                LOW: begin
                    state_d = (cnt_q == WIDTH'(1)) ? HIGH : LOW;
                    cnt_d   = (cnt_q == WIDTH'(1)) ? w_q : cnt_q - WIDTH'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // State and registered outputs, all derived from next-state values
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            launch_q <= 1'b0;
            cnt_q    <= '0;
            num_q    <= '0;
            dly_q    <= '0;
            w_q      <= '0;
            lo_q     <= '0;
            n_q      <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            dly_q    <= dly_d;
            w_q      <= w_d;
            lo_q     <= lo_d;
            n_q      <= n_d;
            pulse_q  <= state_d == HIGH;
            busy_q   <= launch_d || state_d != IDLE;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_pulse_timer.sv
// tb_pulse_timer: directed scenarios checked against an arithmetic timing model and literal expectations
module tb_pulse_timer;
    localparam int WIDTH = 8;
    localparam longint MAXV = 255;
    logic clk = 1'b0;
    logic reset, start, abort;
    logic [WIDTH-1:0] delay, width, period, n_pulses, pulse_num;
    logic pulse, busy, done;
    int compared = 0;
    int mismatched = 0;

    pulse_timer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .delay(delay), .width(width), .period(period), .n_pulses(n_pulses),
        .pulse(pulse), .busy(busy), .done(done), .pulse_num(pulse_num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: outputs after edge e follow from t = e - acceptance edge and the effective timing
    longint ecount = 0, mk, mD, mW, mP, mN, t, u, f, end_t;
    bit     mactive = 0;
    logic   m_pulse = 0, m_busy = 0, m_done = 0;
    longint m_num = 0;
    always @(posedge clk) begin
        if (reset) begin
            mactive = 0; m_pulse = 0; m_busy = 0; m_done = 0; m_num = 0;
        end else if (mactive && abort) begin
            mactive = 0; m_pulse = 0; m_busy = 0; m_done = 0;
        end else if (mactive) begin
            t = ecount - mk;
            end_t = 1 + mD + (mN - 1) * mP + mW;
            if (mN > 0 && t >= end_t) begin
                m_pulse = 0; m_busy = 0; m_done = (t == end_t); m_num = mN % (MAXV + 1); mactive = 0;
            end else begin
                u = t - 1 - mD;
                f = u - mW;
                m_pulse = (u >= 0) ? ((u % mP) < mW) : 1'b0;
                m_busy = 1; m_done = 0;
                m_num = (f < 0) ? 0 : (f / mP + 1) % (MAXV + 1);
            end
        end else begin
            m_pulse = 0; m_done = 0; m_busy = 0;
            if (start && !abort) begin
                mactive = 1; mk = ecount; m_busy = 1; m_num = 0;
                mD = longint'(delay);
                mW = (width == 0) ? 1 : ((longint'(width) == MAXV) ? MAXV - 1 : longint'(width));
                mP = (longint'(period) > mW) ? longint'(period) : mW + 1;
                mN = longint'(n_pulses);
            end
        end
        ecount++;
        #1;
        chk("pulse", pulse, m_pulse);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("pulse_num", pulse_num, m_num);
    end

    // Starts a train on the next edge (start must already be high) and records per-cycle outputs
    task automatic capture(input int len, input int abort_at, input int meddle_at,
                           output logic [63:0] pm, output logic [63:0] dm, output logic [63:0] bm,
                           output int hi, output int done_c);
        pm = '0; dm = '0; bm = '0; hi = 0; done_c = 0;
        @(posedge clk);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c < 64) begin
                pm[c] = pulse; dm[c] = done; bm[c] = busy;
            end
            hi += int'(pulse);
            if (done) done_c = c;
            abort = (c == abort_at);
            if (c == meddle_at) begin
                start = 1'b1; delay = 8'd7; width = 8'd1; period = 8'd9;
            end
            if (c == meddle_at + 1) start = 1'b0;
        end
    endtask

    task automatic setp(input int d, input int w, input int p, input int n);
        delay = 8'(d); width = 8'(w); period = 8'(p); n_pulses = 8'(n);
    endtask

    logic [63:0] pm, dm, bm;
    int hi, done_c;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        setp(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset pulse_num", pulse_num, 0);
        reset = 1'b0;
        @(negedge clk);

        setp(3, 2, 5, 3); start = 1'b1;
        capture(20, 0, 0, pm, dm, bm, hi, done_c);
        chk("basic pulse mask", pm, 64'h18C60);
        chk("basic done mask", dm, 64'h20000);
        chk("basic busy mask", bm, 64'h1FFFE);
        chk("basic pulse_num", pulse_num, 3);

        setp(0, 0, 0, 2); start = 1'b1;
        capture(8, 0, 0, pm, dm, bm, hi, done_c);
        chk("zero pulse mask", pm, 64'h14);
        chk("zero done mask", dm, 64'h20);
        chk("zero busy mask", bm, 64'h1E);
        chk("zero pulse_num", pulse_num, 2);

        setp(0, 1, 4, 0); start = 1'b1;
        capture(14, 10, 0, pm, dm, bm, hi, done_c);
        chk("abort pulse mask", pm, 64'h444);
        chk("abort busy mask", bm, 64'h7FE);
        chk("abort done mask", dm, 64'h0);
        chk("abort pulse_num", pulse_num, 2);

        setp(3, 2, 5, 3); start = 1'b1;
        capture(20, 0, 3, pm, dm, bm, hi, done_c);
        chk("restart pulse mask", pm, 64'h18C60);
        chk("restart done mask", dm, 64'h20000);
        chk("restart busy mask", bm, 64'h1FFFE);

        start = 1'b1; abort = 1'b1;
        repeat (3) @(negedge clk);
        chk("start+abort busy", busy, 0);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);

        setp(6, 2, 5, 2); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("in delay busy", busy, 1);
        reset = 1'b1; start = 1'b1;
        setp(2, 1, 3, 2);
        @(negedge clk);
        chk("mid reset busy", busy, 0);
        chk("mid reset pulse", pulse, 0);
        chk("mid reset done", done, 0);
        chk("mid reset pulse_num", pulse_num, 0);
        reset = 1'b0;
        capture(10, 0, 0, pm, dm, bm, hi, done_c);
        chk("post reset pulse mask", pm, 64'h90);
        chk("post reset done mask", dm, 64'h100);
        chk("post reset busy mask", bm, 64'hFE);

        setp(0, 255, 255, 2); start = 1'b1;
        capture(515, 0, 0, pm, dm, bm, hi, done_c);
        chk("saturate high cycles", hi, 508);
        chk("saturate done cycle", done_c, 511);
        chk("saturate pulse_num", pulse_num, 2);

        setp(0, 1, 2, 0); start = 1'b1;
        capture(602, 600, 0, pm, dm, bm, hi, done_c);
        chk("wrap high cycles", hi, 300);
        chk("wrap done cycle", done_c, 0);
        chk("wrap pulse_num", pulse_num, 43);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
